apb_bus_arbiter: RTL and testbench

//  Shares one APB master port between NREQ requesters (CPU-side agents).
//  - Arbitrates round-robin and sequences the APB IDLE/SETUP/ACCESS protocol.
//  - Decodes PADDR MSB into PSEL1/PSEL2 and returns read data and error to the winning requester.
//  - Sits between the requesters and the APB slaves; it is the only driver of the APB bus.

---
 rtl/apb_arb_pkg.sv | 17 +
 rtl/apb_rr_arbiter.sv | 53 +++++
 rtl/apb_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizes for the APB bus arbiter slice.
// Used by apb_rr_arbiter and apb_bus_arbiter through import apb_arb_pkg::*.
package apb_arb_pkg;

  // APB transfer sequencer states (also visible on the debug state port).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_NREQ        = 2;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin requester selection for the APB bus arbiter.
// Grant is combinational (one-hot plus index) from the eligible mask and the
// priority pointer; the pointer moves to the slot after the winner only when
// the grant is actually taken (advance=1).
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] elig,
  input  logic            advance,
  output logic [NREQ-1:0] grant_oh,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] ptr_q;
  logic [PW:0]   cand;
  logic          found;

  // Scan requesters starting at the pointer, wrapping once; first eligible wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!found && elig[cand[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Priority pointer: requester 0 first after reset, then the slot after each winner.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master port between NREQ requesters.
// Round-robin selection, IDLE/SETUP/ACCESS sequencing, PSEL1/PSEL2 decode from
// the address MSB, read data and error returned to the winner.
// Optional feature macro: APB_TIMEOUT_EN -- ends an ACCESS phase that sees no
// PREADY for TIMEOUT_CYC cycles as a completion with err_o=1 and rdata_o=0.
//
// Requester handshake: req_i[n] is a level request with addr/write/wdata held
// stable alongside it; the arbiter answers with a single-cycle done_o[n] pulse
// (err_o valid in that same cycle) and the requester must drop req_i[n] in that
// cycle. The completing requester is masked from arbitration during its pulse.
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NREQ-1:0]              write_i,
  input  logic [NREQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [NREQ-1:0]              done_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         err_o,
  output logic                         PSEL1,
  output logic                         PSEL2,
  output logic                         PEN,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W-1:0]            PRDATA,
  input  logic                         PREADY,
  input  logic                         PSLVERR,
  output logic [1:0]                   dbg_state_o
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_bus_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  apb_state_t state_q, state_d;

  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant_oh;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic              win;
  logic              tmo_hit;
  logic              xfer_end;

  logic              psel1_d, psel2_d, pen_d, pwrite_d, err_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rdata_d;
  logic [NREQ-1:0]   done_d;

  // A requester whose completion pulse is showing cannot win again this cycle.
  assign elig = req_i & ~done_o;

  apb_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .elig      (elig),
    .advance   (state_q == IDLE),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign win         = (state_q == IDLE) && (|grant_oh);
  assign xfer_end    = (state_q == ACCESS) && (PREADY || tmo_hit);
  assign dbg_state_o = state_q;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q;

  // Count ACCESS cycles without PREADY; cleared whenever not in ACCESS.
  always_ff @(posedge CLK) begin
    if (!RST_N || state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (!PREADY) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !PREADY &&
                   (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant starts SETUP, SETUP lasts one cycle, ACCESS ends on PREADY or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: latch the winner's request, raise PEN, close out on completion.
  always_comb begin
    psel1_d  = PSEL1;
    psel2_d  = PSEL2;
    pen_d    = PEN;
    pwrite_d = PWRITE;
    paddr_d  = PADDR;
    pwdata_d = PWDATA;
    rdata_d  = rdata_o;
    err_d    = 1'b0;
    done_d   = '0;
    gnt_d    = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (win) begin
          gnt_d    = grant_idx;
          paddr_d  = addr_i[grant_idx];
          pwrite_d = write_i[grant_idx];
          pwdata_d = wdata_i[grant_idx];
          psel1_d  = ~addr_i[grant_idx][ADDR_W-1];
          psel2_d  = addr_i[grant_idx][ADDR_W-1];
          pen_d    = 1'b0;
        end
      end
      SETUP: begin
        pen_d = 1'b1;
      end
      ACCESS: begin
        if (xfer_end) begin
          psel1_d       = 1'b0;
          psel2_d       = 1'b0;
          pen_d         = 1'b0;
          done_d[gnt_q] = 1'b1;
          if (tmo_hit) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d = PSLVERR;
            if (!PWRITE) begin
              rdata_d = PRDATA;
            end
          end
        end
      end
      default: begin
        psel1_d = 1'b0;
        psel2_d = 1'b0;
        pen_d   = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears the bus and abandons any transfer silently.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      PEN     <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      done_o  <= '0;
      gnt_q   <= '0;
    end else begin
      PSEL1   <= psel1_d;
      PSEL2   <= psel2_d;
      PEN     <= pen_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      rdata_o <= rdata_d;
      err_o   <= err_d;
      done_o  <= done_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: requester driver, APB slave responder, monitor with
// scoreboard queue, directed cases followed by random batches.
module tb_apb_bus_arbiter;

  localparam int NREQ        = 2;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 4;
  localparam int STUCK       = 100000;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic                        CLK;
  logic                        RST_N;
  logic [NREQ-1:0]             req_i;
  logic [NREQ-1:0][ADDR_W-1:0] addr_i;
  logic [NREQ-1:0]             write_i;
  logic [NREQ-1:0][DATA_W-1:0] wdata_i;
  logic [NREQ-1:0]             done_o;
  logic [DATA_W-1:0]           rdata_o;
  logic                        err_o;
  logic                        PSEL1, PSEL2, PEN, PWRITE;
  logic [ADDR_W-1:0]           PADDR;
  logic [DATA_W-1:0]           PWDATA;
  logic [DATA_W-1:0]           PRDATA;
  logic                        PREADY, PSLVERR;
  logic [1:0]                  dbg_state_o;

  apb_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .req_i(req_i), .addr_i(addr_i), .write_i(write_i),
    .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PEN(PEN), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state_o)
  );

  typedef struct {
    int                req;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] prdata;
    logic              slverr;
    int                waits;
    logic              first;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    int                exp_pen;
  } txn_t;

  txn_t exp_q[$];
  txn_t rsp_q[$];
  txn_t drv_q[NREQ][$];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int raise_cyc[NREQ];
  int n_done = 0;
  int last_done_cyc = 0;

  // Reference model state: next-priority requester and last returned read data.
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_rdata = '0;

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: got cycle %0d, required finish earlier", cyc);
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic txn_t rand_txn(input int r, input logic first);
    txn_t t;
    t.req       = r;
    t.addr      = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
    t.wr        = 1'($urandom_range(0, 1));
    t.wdata     = DATA_W'($urandom_range(0, 255));
    t.prdata    = DATA_W'($urandom_range(0, 255));
    t.slverr    = ($urandom_range(0, 3) == 0);
    t.waits     = $urandom_range(0, 3);
    t.first     = first;
    t.exp_rdata = '0;
    t.exp_err   = 1'b0;
    t.exp_pen   = 0;
    return t;
  endfunction

  // Record a transfer in service order: expected result, driver work, slave response.
  task automatic add_txn(input txn_t t);
    if (TMO_ON && t.waits >= TIMEOUT_CYC) begin
      m_rdata   = '0;
      t.exp_err = 1'b1;
      t.exp_pen = TIMEOUT_CYC;
    end else begin
      if (!t.wr) m_rdata = t.prdata;
      t.exp_err = t.slverr;
      t.exp_pen = t.waits + 1;
    end
    t.exp_rdata = m_rdata;
    m_ptr = (t.req + 1) % NREQ;
    exp_q.push_back(t);
    rsp_q.push_back(t);
    drv_q[t.req].push_back(t);
  endtask

  // All requesters in mask raise together; they are served in rotation from m_ptr.
  task automatic run_batch(input int mask, input int fixed_waits);
    int   start;
    int   r;
    logic first;
    txn_t t;
    start = m_ptr;
    first = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      r = (start + k) % NREQ;
      if (mask[r]) begin
        t = rand_txn(r, first);
        if (fixed_waits >= 0) t.waits = fixed_waits;
        add_txn(t);
        first = 1'b0;
      end
    end
  endtask

  function automatic int drv_pending();
    int s;
    s = 0;
    for (int r = 0; r < NREQ; r++) s += drv_q[r].size();
    return s;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    rsp_q.delete();
    for (int r = 0; r < NREQ; r++) drv_q[r].delete();
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    flush_model();
    RST_N = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || drv_pending() > 0) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    if (exp_q.size() > 0) do_reset();
  endtask

  task automatic chk_bus_zero(input string tag);
    chk({tag, "_psel1"},  32'(PSEL1),   32'd0);
    chk({tag, "_psel2"},  32'(PSEL2),   32'd0);
    chk({tag, "_pen"},    32'(PEN),     32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE),  32'd0);
    chk({tag, "_paddr"},  32'(PADDR),   32'd0);
    chk({tag, "_pwdata"}, 32'(PWDATA),  32'd0);
    chk({tag, "_done"},   32'(done_o),  32'd0);
    chk({tag, "_err"},    32'(err_o),   32'd0);
    chk({tag, "_rdata"},  32'(rdata_o), 32'd0);
    chk({tag, "_state"},  32'(dbg_state_o), 32'd0);
  endtask

  // ---------------- requester driver ----------------
  initial begin
    bit   active[NREQ];
    txn_t t;
    req_i   = '0;
    addr_i  = '0;
    write_i = '0;
    wdata_i = '0;
    for (int r = 0; r < NREQ; r++) active[r] = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (!RST_N) begin
          req_i[r]  = 1'b0;
          active[r] = 1'b0;
        end else if (active[r]) begin
          if (done_o[r]) begin
            req_i[r]  = 1'b0;
            active[r] = 1'b0;
          end
        end else if (drv_q[r].size() > 0) begin
          t            = drv_q[r].pop_front();
          addr_i[r]    = t.addr;
          write_i[r]   = t.wr;
          wdata_i[r]   = t.wdata;
          req_i[r]     = 1'b1;
          active[r]    = 1'b1;
          raise_cyc[r] = cyc;
        end
      end
    end
  end

  // ---------------- APB slave responder ----------------
  initial begin
    bit   busy;
    int   wcnt;
    txn_t cur;
    busy    = 1'b0;
    wcnt    = 0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        busy   = 1'b0;
        PREADY = 1'b0;
      end else begin
        if (busy && !(PSEL1 || PSEL2)) busy = 1'b0;
        if (!busy && (PSEL1 || PSEL2) && PEN) begin
          busy = 1'b1;
          wcnt = 0;
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else cur.waits = 0;
        end
        if (busy) begin
          if (wcnt == cur.waits) begin
            PREADY  = 1'b1;
            PRDATA  = cur.prdata;
            PSLVERR = cur.slverr;
            busy    = 1'b0;
          end else begin
            PREADY  = 1'b0;
            PRDATA  = DATA_W'($urandom_range(0, 255));
            PSLVERR = 1'($urandom_range(0, 1));
            wcnt++;
          end
        end else begin
          // Noise outside ACCESS must be ignored by the arbiter.
          PREADY  = 1'($urandom_range(0, 1));
          PRDATA  = DATA_W'($urandom_range(0, 255));
          PSLVERR = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit   in_xfer;
    int   t_sel;
    int   pen_cnt;
    txn_t e;
    in_xfer = 1'b0;
    t_sel   = 0;
    pen_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        in_xfer = 1'b0;
      end else begin
        if ((PSEL1 || PSEL2) && !PEN && !in_xfer) begin
          chk("pending_at_grant", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("paddr",  32'(PADDR),  32'(e.addr));
            chk("pwrite", 32'(PWRITE), 32'(e.wr));
            chk("pwdata", 32'(PWDATA), 32'(e.wdata));
            chk("psel1",  32'(PSEL1),  32'(!e.addr[ADDR_W-1]));
            chk("psel2",  32'(PSEL2),  32'(e.addr[ADDR_W-1]));
            if (e.first) chk("sel_latency", 32'(cyc - raise_cyc[e.req]), 32'd1);
          end
          in_xfer = 1'b1;
          t_sel   = cyc;
          pen_cnt = 0;
        end else if (in_xfer && PEN) begin
          if (pen_cnt == 0) chk("pen_latency", 32'(cyc - t_sel), 32'd1);
          chk("access_paddr_hold", 32'(PADDR), 32'(e.addr));
          chk("access_psel_hold", 32'({PSEL1, PSEL2}),
              32'({!e.addr[ADDR_W-1], e.addr[ADDR_W-1]}));
          chk("access_state", 32'(dbg_state_o), 32'd2);
          pen_cnt++;
        end
        if (done_o != '0) begin
          chk("done_while_pending", 32'(in_xfer && exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_o",        32'(done_o),  32'(1 << e.req));
            chk("err_o",         32'(err_o),   32'(e.exp_err));
            chk("rdata_o",       32'(rdata_o), 32'(e.exp_rdata));
            chk("access_cycles", 32'(pen_cnt), 32'(e.exp_pen));
            chk("bus_released",  32'({PSEL1, PSEL2, PEN}), 32'd0);
          end
          in_xfer       = 1'b0;
          n_done++;
          last_done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    txn_t t;
    int   t0;
    int   k;
    int   n0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_bus_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Single write to slave 1.
    t = rand_txn(0, 1'b1);
    t.addr = 9'h005; t.wr = 1'b1; t.wdata = 8'hA5; t.waits = 0; t.slverr = 1'b0;
    add_txn(t);
    wait_done("single_write_done", 50);

    // Read from slave 2 with two wait states.
    t = rand_txn(1, 1'b1);
    t.addr = 9'h105; t.wr = 1'b0; t.prdata = 8'h3C; t.waits = 2; t.slverr = 1'b0;
    add_txn(t);
    wait_done("read_slave2_done", 50);

    // Slave error then a clean write from the same requester.
    t = rand_txn(0, 1'b1);
    t.wr = 1'b1; t.waits = 0; t.slverr = 1'b1;
    add_txn(t);
    wait_done("slverr_done", 50);
    t = rand_txn(0, 1'b1);
    t.wr = 1'b1; t.waits = 1; t.slverr = 1'b0;
    add_txn(t);
    wait_done("after_err_done", 50);

    // Both requesters held continuously: ten alternating grants, no idle gap.
    @(negedge CLK);
    t0 = cyc;
    k  = m_ptr;
    for (int n = 0; n < 10; n++) begin
      t = rand_txn((k + n) % NREQ, n == 0);
      t.waits = 0;
      add_txn(t);
    end
    wait_done("stream_done", 100);
    chk("stream_span", 32'(last_done_cyc - t0), 32'd31);

`ifdef APB_TIMEOUT_EN
    // Slave never answers: the transfer is closed by the timeout.
    t = rand_txn(0, 1'b1);
    t.wr = 1'b0; t.waits = STUCK;
    add_txn(t);
    wait_done("timeout_done", 50);
`endif

    // Random batches of simultaneous requests.
    for (int b = 0; b < 40; b++) begin
      run_batch($urandom_range(1, (1 << NREQ) - 1), -1);
      wait_done("batch_done", 60);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    // Reset in the middle of an ACCESS phase from requester 1.
    t = rand_txn(1, 1'b1);
    t.waits = STUCK;
    add_txn(t);
    k = 0;
    while (!PEN && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("reached_access", 32'(PEN), 32'd1);
    n0 = n_done;
`ifndef APB_TIMEOUT_EN
    repeat (100) @(negedge CLK);
    chk("stuck_no_done", 32'(n_done - n0), 32'd0);
    chk("stuck_still_access", 32'(dbg_state_o), 32'd2);
`endif
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk_bus_zero("mid_reset");
    @(negedge CLK);
    chk("reset_no_done", 32'(n_done - n0), 32'd0);
    flush_model();
    RST_N = 1'b1;
    @(negedge CLK);

    // After reset requester 0 has priority again.
    run_batch(3, -1);
    wait_done("post_reset_batch", 60);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
